// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sort_pkg
// Brief    : Shared sizes and state encoding for the byte sorter and its
//            stream-side sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sort_pkg;

    localparam int N_ELEM = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Index of the final element; read and write counters saturate here.
    function automatic logic [ADDR_W-1:0] last_idx();
        return ADDR_W'(N_ELEM - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sort_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sort_out_fifo
// Brief    : Synchronous FIFO buffering sorted bytes (data + last flag).
//            Push while full is accepted only together with a pop.
// Revision : 1.0 - initial release
// ============================================================================
module sort_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sort_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sort_sequencer
// Brief    : Loads an 8-byte batch into the byte sorter, starts it, waits for
//            completion and streams the sorted bytes out with a last flag.
//            Define SORT_SEQ_REVERSE_EN to drain in descending order.
// Revision : 1.0 - initial release
// ============================================================================
module sort_sequencer
    import sort_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              srt_wr,
    output logic [ADDR_W-1:0] srt_addr,
    output logic [DATA_W-1:0] srt_data,
    output logic              srt_start,
    input  logic              srt_ready,
    input  logic [DATA_W-1:0] srt_data_out
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] c_LAST_IDX = last_idx();

    state_t             r_state;
    logic               r_in_ready;
    logic               r_srt_wr;
    logic [ADDR_W-1:0]  r_srt_addr;
    logic [DATA_W-1:0]  r_srt_data;
    logic               r_srt_start;
    logic [ADDR_W-1:0]  r_wr_cnt;
    logic               r_wr_done;
    logic [ADDR_W-1:0]  r_rd_cnt;
    logic               r_rd_done;
    logic               r_busy_seen;
    logic               r_rd_act;
    logic               r_rd_last;
    logic [RD_LAT-1:0]  r_vsr;
    logic [RD_LAT-1:0]  r_lsr;

    logic [ADDR_W-1:0]  w_rd_addr;
    logic [INF_W-1:0]   w_inflight;
    logic [INF_W-1:0]   w_free;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic [DATA_W:0]    w_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [CNT_W-1:0]   w_fifo_count;

`ifdef SORT_SEQ_REVERSE_EN
    assign w_rd_addr = c_LAST_IDX - r_rd_cnt;
`else
    assign w_rd_addr = r_rd_cnt;
`endif

    // Reads presented on srt_addr but not yet landed in the FIFO.
    always_comb begin
        w_inflight = INF_W'(r_rd_act);
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + INF_W'(r_vsr[i]);
        end
    end

    // A pop this cycle frees its slot before the next read could land.
    assign w_free  = INF_W'(FIFO_DEPTH) - INF_W'(w_fifo_count) + INF_W'(w_pop);
    assign w_issue = (r_state == DRAIN) && !r_rd_done && (w_free > w_inflight);
    assign w_push  = r_vsr[RD_LAT-1];
    assign w_pop   = !w_fifo_empty && out_ready;

    sort_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (w_push),
        .push_data ({r_lsr[RD_LAT-1], srt_data_out}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!nrst)
        !(w_fifo_full && w_push && !w_pop));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= LOAD;
            r_in_ready  <= 1'b0;
            r_srt_wr    <= 1'b0;
            r_srt_addr  <= '0;
            r_srt_data  <= '0;
            r_srt_start <= 1'b0;
            r_wr_cnt    <= '0;
            r_wr_done   <= 1'b0;
            r_rd_cnt    <= '0;
            r_rd_done   <= 1'b0;
            r_busy_seen <= 1'b0;
            r_rd_act    <= 1'b0;
            r_rd_last   <= 1'b0;
            r_vsr       <= '0;
            r_lsr       <= '0;
        end else begin
            r_rd_act  <= w_issue;
            r_rd_last <= w_issue && (r_rd_cnt == c_LAST_IDX);
            r_vsr[0]  <= r_rd_act;
            r_lsr[0]  <= r_rd_last;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vsr[i] <= r_vsr[i-1];
                r_lsr[i] <= r_lsr[i-1];
            end

            unique case (r_state)
                LOAD: begin
                    r_srt_wr   <= 1'b0;
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready && !r_wr_done) begin
                        r_srt_wr   <= 1'b1;
                        r_srt_addr <= r_wr_cnt;
                        r_srt_data <= in_data;
                        if (r_wr_cnt == c_LAST_IDX) begin
                            r_wr_done  <= 1'b1;
                            r_in_ready <= 1'b0;
                            r_state    <= START;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
                        end
                    end
                end
                START: begin
                    r_srt_wr <= 1'b0;
                    // The final write must have been presented before start.
                    if (srt_ready && !r_srt_wr) begin
                        r_srt_start <= 1'b1;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    r_srt_start <= 1'b0;
                    if (!srt_ready) begin
                        r_busy_seen <= 1'b1;
                    end else if (r_busy_seen) begin
                        r_busy_seen <= 1'b0;
                        r_state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_issue) begin
                        r_srt_addr <= w_rd_addr;
                        if (r_rd_cnt == c_LAST_IDX) begin
                            r_rd_done <= 1'b1;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
                        end
                    end
                    if (w_pop && w_head[DATA_W]) begin
                        r_state    <= LOAD;
                        r_in_ready <= 1'b1;
                        r_wr_cnt   <= '0;
                        r_wr_done  <= 1'b0;
                        r_rd_cnt   <= '0;
                        r_rd_done  <= 1'b0;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign srt_wr    = r_srt_wr;
    assign srt_addr  = r_srt_addr;
    assign srt_data  = r_srt_data;
    assign srt_start = r_srt_start;
    assign out_valid = !w_fifo_empty;
    assign out_data  = w_fifo_empty ? '0 : w_head[DATA_W-1:0];
    assign out_last  = !w_fifo_empty && w_head[DATA_W];

endmodule
`default_nettype wire

// File: tb/tb_sort_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_sequencer
// Brief    : Self-checking bench for sort_sequencer with a behavioural sorter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sort_sequencer;

    localparam int SORT_CYC = 20;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b0;
    logic       srt_wr;
    logic [2:0] srt_addr;
    logic [7:0] srt_data;
    logic       srt_start;
    logic       srt_ready;
    logic [7:0] srt_data_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sort_sequencer #(
        .RD_LAT     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .srt_wr       (srt_wr),
        .srt_addr     (srt_addr),
        .srt_data     (srt_data),
        .srt_start    (srt_start),
        .srt_ready    (srt_ready),
        .srt_data_out (srt_data_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural sorter: 2-cycle read latency, 20-cycle sort.
    logic [63:0] s_mem;
    logic        s_busy;
    int          s_cnt;
    logic [7:0]  s_p1, s_p2;

    function automatic logic [63:0] sort8(input logic [63:0] v);
        logic [7:0]  a [8];
        logic [7:0]  t;
        logic [63:0] r;
        for (int i = 0; i < 8; i++) a[i] = v[i*8 +: 8];
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i];
        return r;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s_mem <= '0; s_busy <= 1'b0; s_cnt <= 0; s_p1 <= '0; s_p2 <= '0;
        end else begin
            s_p1 <= s_mem[srt_addr*8 +: 8];
            s_p2 <= s_p1;
            if (s_busy) begin
                if (s_cnt == 1) begin
                    s_busy <= 1'b0;
                    s_mem  <= sort8(s_mem);
                end
                s_cnt <= s_cnt - 1;
            end else begin
                if (srt_wr) s_mem[srt_addr*8 +: 8] <= srt_data;
                if (srt_start) begin s_busy <= 1'b1; s_cnt <= SORT_CYC; end
            end
        end
    end

    assign srt_ready    = !s_busy;
    assign srt_data_out = s_p2;

    // Reference model: accepted bytes in order; expected output is that batch sorted.
    logic [7:0] acc_q [$];
    logic [7:0] exp_q [$];
    int wr_idx = 0;
    int out_idx = 0;
    int n_start = 0;
    bit batch_done = 1'b0;
    bit chk_rdy = 1'b0;

    always @(negedge clk) begin
        if (!nrst) begin
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_out_data", out_data, 0);
            check_eq("rst_out_last", out_last, 0);
            check_eq("rst_in_ready", in_ready, 0);
            check_eq("rst_srt_wr", srt_wr, 0);
            check_eq("rst_srt_addr", srt_addr, 0);
            check_eq("rst_srt_data", srt_data, 0);
            check_eq("rst_srt_start", srt_start, 0);
            acc_q.delete(); exp_q.delete();
            wr_idx = 0; out_idx = 0; n_start = 0; chk_rdy = 1'b0;
        end else begin
            if (chk_rdy) begin
                check_eq("in_ready_after_last", in_ready, 1);
                chk_rdy = 1'b0;
            end
            if (srt_wr) begin
                check_eq("wr_addr", srt_addr, wr_idx);
                if (wr_idx < acc_q.size()) check_eq("wr_data", srt_data, acc_q[wr_idx]);
                else check_eq("wr_extra", wr_idx, acc_q.size());
                wr_idx++;
            end
            if (in_valid && in_ready) acc_q.push_back(in_data);
            if (srt_start) begin
                n_start++;
                check_eq("start_after_writes", {wr_idx == 8, srt_wr}, 2'b10);
                exp_q = acc_q;
`ifdef SORT_SEQ_REVERSE_EN
                exp_q.rsort();
`else
                exp_q.sort();
`endif
            end
            if (out_valid && out_ready) begin
                if (out_idx < exp_q.size()) check_eq("out_data", out_data, exp_q[out_idx]);
                else check_eq("out_extra", out_idx, exp_q.size());
                check_eq("out_last", out_last, out_idx == 7);
                out_idx++;
                if (out_last) begin
                    check_eq("out_count", out_idx, 8);
                    check_eq("start_pulses", n_start, 1);
                    acc_q.delete(); exp_q.delete();
                    wr_idx = 0; out_idx = 0; n_start = 0;
                    batch_done = 1'b1;
                    chk_rdy = 1'b1;
                end
            end
        end
    end

    // out_ready: 0 = steady, 1 = pattern 1,0,0, else random.
    int rdy_mode = 0;
    int rdy_ph = 0;
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (rdy_ph == 0); rdy_ph = (rdy_ph + 1) % 3; end
            default: out_ready = ($urandom_range(0, 1) == 1);
        endcase
    end

    // gap < 0: random in_valid; otherwise valid every (gap+1)th cycle.
    task automatic send_batch(input logic [63:0] b, input int gap);
        int i = 0;
        int cyc = 0;
        batch_done = 1'b0;
        while (i < 8 && cyc < 500) begin
            @(posedge clk); #1;
            in_valid = (gap < 0) ? ($urandom_range(0, 2) == 0) : ((cyc % (gap + 1)) == 0);
            in_data  = in_valid ? b[i*8 +: 8] : 8'($urandom);
            cyc++;
            @(negedge clk);
            if (in_valid && in_ready) i++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("load_timeout", i, 8);
    endtask

    task automatic wait_done();
        int guard = 0;
        while (!batch_done && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("batch_timeout", batch_done, 1);
    endtask

    initial begin
        int guard;
        #2 nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk); @(negedge clk);
        check_eq("in_ready_post_rst", in_ready, 1);

        rdy_mode = 0;
        send_batch(64'h04_06_02_07_01_05_03_08, 0);
        wait_done();

        send_batch({$urandom, $urandom}, 2);
        wait_done();

        rdy_mode = 1;
        send_batch(64'h04_06_02_07_01_05_03_08, 0);
        wait_done();

        rdy_mode = 0;
        send_batch(64'hFFFF_FFFF_FFFF_FFFF, 0);
        wait_done();

        // Reset in the middle of DRAIN, then a fresh batch.
        send_batch(64'h04_06_02_07_01_05_03_08, 0);
        guard = 0;
        while (out_idx < 3 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("drain_timeout", out_idx >= 3, 1);
        @(posedge clk); #1;
        nrst = 1'b0;
        #1;
        check_eq("async_rst_out_valid", out_valid, 0);
        check_eq("async_rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        send_batch(64'h07_08_02_01_04_04_00_09, 0);
        wait_done();

        for (int k = 0; k < 6; k++) begin
            rdy_mode = $urandom_range(0, 2);
            send_batch({$urandom, $urandom}, $urandom_range(0, 3) - 1);
            wait_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
